// File: rtl/fetch_unit.sv
// Instruction fetch stage: loads the start PC from a two-word reset vector,
// then assembles 16/32-bit instructions from a 16-bit instruction memory.
module fetch_unit #(
  parameter int unsigned             MEM_AW    = 20,
  parameter logic [MEM_AW-1:0]       RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              o_valid,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_instruction,
  output logic              o_buf_enable
);

  typedef enum logic [1:0] {VEC_HI, VEC_LO, FETCH1, FETCH2} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] hold_q, hold_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] o_pc_q, o_pc_d;
  logic [31:0] o_instr_q, o_instr_d;
  logic        o_valid_q, o_valid_d;
  logic [31:0] pc_inc;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    inst_pc_d = inst_pc_q;
    o_pc_d    = o_pc_q;
    o_instr_d = o_instr_q;
    o_valid_d = o_valid_q;
    mem_addr  = pc_q[MEM_AW-1:0];
    pc_inc    = pc_q + 32'd1;

    case (state_q)
      VEC_HI: begin
        mem_addr = RESET_VEC;
        if (!stall) begin
          pc_d    = {mem_rdata, pc_q[15:0]};
          state_d = VEC_LO;
        end
      end
      VEC_LO: begin
        mem_addr = RESET_VEC + MEM_AW'(1);
        if (!stall) begin
          pc_d    = {pc_q[31:16], mem_rdata};
          state_d = FETCH1;
        end
      end
      FETCH1: begin
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          hold_d    = '0;
          o_valid_d = 1'b0;
          state_d   = FETCH1;
        end else if (!stall) begin
          pc_d = pc_inc;
          // Bit 0 of the first word flags a two-word instruction
          if (mem_rdata[0]) begin
            hold_d    = mem_rdata;
            inst_pc_d = pc_q;
            o_valid_d = 1'b0;
            state_d   = FETCH2;
          end else begin
            o_instr_d = {mem_rdata, 16'h0000};
            o_pc_d    = pc_q;
            o_valid_d = 1'b1;
          end
        end
      end
      FETCH2: begin
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          hold_d    = '0;
          o_valid_d = 1'b0;
          state_d   = FETCH1;
        end else if (!stall) begin
          pc_d      = pc_inc;
          o_instr_d = {hold_q, mem_rdata};
          o_pc_d    = inst_pc_q;
          o_valid_d = 1'b1;
          state_d   = FETCH1;
        end
      end
      default: begin
        mem_addr = RESET_VEC;
        state_d  = VEC_HI;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= VEC_HI;
      pc_q      <= '0;
      hold_q    <= '0;
      inst_pc_q <= '0;
      o_pc_q    <= '0;
      o_instr_q <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      inst_pc_q <= inst_pc_d;
      o_pc_q    <= o_pc_d;
      o_instr_q <= o_instr_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_valid       = o_valid_q;
  assign o_pc          = o_pc_q;
  assign o_instruction = o_instr_q;
  assign o_buf_enable  = o_valid_q & ~stall;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing checks plus a randomized run scored
// against an instruction-stream model of memory contents.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [19:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic        o_buf_enable;

  always #5 clk = ~clk;

  fetch_unit #(.MEM_AW(20), .RESET_VEC(20'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .o_valid(o_valid), .o_pc(o_pc), .o_instruction(o_instruction),
    .o_buf_enable(o_buf_enable)
  );

  // Sparse memory; unwritten words come from a fixed address hash
  logic [15:0] mem [logic [19:0]];
  int          mem_gen = 0;

  function automatic logic [15:0] fill(input logic [19:0] a);
    logic [31:0] t;
    t = {12'h0, a} * 32'd40503 + 32'h5A5;
    return t[15:0];
  endfunction

  function automatic logic [15:0] rd(input logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    return fill(a);
  endfunction

  task automatic wr(input logic [19:0] a, input logic [15:0] d);
    mem[a] = d;
    mem_gen++;
  endtask

  always @(mem_addr or mem_gen) mem_rdata = rd(mem_addr);

  int checks = 0;
  int passes = 0;
  int captures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: walks the instruction stream in memory from a start PC
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;

  task automatic push_one();
    logic [15:0] w0;
    logic [15:0] w1;
    w0 = rd(model_pc[19:0]);
    if (w0[0]) begin
      w1 = rd(20'(model_pc + 32'd1));
      exp_q.push_back({model_pc, w0, w1});
      model_pc = model_pc + 32'd2;
    end else begin
      exp_q.push_back({model_pc, w0, 16'h0000});
      model_pc = model_pc + 32'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst && redirect_valid) begin
      exp_q.delete();
      model_pc = redirect_pc;
    end
    while (exp_q.size() < 8) push_one();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    model_pc = {rd(20'h0), rd(20'h1)};
    while (exp_q.size() < 8) push_one();
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [19:0] ma);
    check({nm, "_valid"}, {63'h0, o_valid}, {63'h0, v});
    check({nm, "_pc"}, {32'h0, o_pc}, {32'h0, pc});
    check({nm, "_inst"}, {32'h0, o_instruction}, {32'h0, ins});
    check({nm, "_addr"}, {44'h0, mem_addr}, {44'h0, ma});
  endtask

  // Monitor: every presented instruction must match the stream head; a buffer
  // capture consumes it
  always @(negedge clk) begin
    if (rst) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_empty", 64'h1, 64'h0);
        end else begin
          check("stream_pc", {32'h0, o_pc}, {32'h0, exp_q[0][63:32]});
          check("stream_inst", {32'h0, o_instruction}, {32'h0, exp_q[0][31:0]});
          if (o_buf_enable) begin
            void'(exp_q.pop_front());
            captures++;
          end
        end
      end else if (o_buf_enable) begin
        check("buf_en_without_valid", 64'h1, 64'h0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    wr(20'h0, 16'h0000);
    wr(20'h1, 16'h0040);
    wr(20'h40, 16'h1000);
    wr(20'h41, 16'h2002);
    wr(20'h42, 16'h3004);
    wr(20'h43, 16'h1001);
    wr(20'h44, 16'hBEEF);
    wr(20'h45, 16'h7001);
    wr(20'h46, 16'h1234);
    wr(20'h80, 16'h2222);
    wr(20'h90, 16'h3003);
    wr(20'h91, 16'h4444);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 32'h0, 20'h0);
    check("reset_buf_en", {63'h0, o_buf_enable}, 64'h0);

    release_reset();
    check("vec_hi_addr", {44'h0, mem_addr}, 64'h0);
    tick(); check("vec_lo_addr", {44'h0, mem_addr}, 64'h1);
    check("vec_no_valid", {63'h0, o_valid}, 64'h0);
    tick(); check("fetch_start_addr", {44'h0, mem_addr}, 64'h40);
    check("vec_no_valid2", {63'h0, o_valid}, 64'h0);

    tick(); chk_out("short0", 1'b1, 32'h40, 32'h1000_0000, 20'h41);
    tick(); chk_out("short1", 1'b1, 32'h41, 32'h2002_0000, 20'h42);
    tick(); chk_out("short2", 1'b1, 32'h42, 32'h3004_0000, 20'h43);
    tick(); chk_out("long_bubble", 1'b0, 32'h42, 32'h3004_0000, 20'h44);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall_fetch2", 1'b0, 32'h42, 32'h3004_0000, 20'h44);
      check("stall_buf_en", {63'h0, o_buf_enable}, 64'h0);
    end
    stall = 1'b0;
    tick(); chk_out("long_out", 1'b1, 32'h43, 32'h1001_BEEF, 20'h45);
    check("long_buf_en", {63'h0, o_buf_enable}, 64'h1);

    stall = 1'b1;
    #1 check("stall_valid_buf_en", {63'h0, o_buf_enable}, 64'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("stall_hold", 1'b1, 32'h43, 32'h1001_BEEF, 20'h45);
    end
    stall = 1'b0;
    tick(); chk_out("second_long", 1'b0, 32'h43, 32'h1001_BEEF, 20'h46);

    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick(); chk_out("redirect", 1'b0, 32'h43, 32'h1001_BEEF, 20'h80);
    redirect_valid = 1'b0;
    stall = 1'b0;
    tick(); chk_out("redirect_target", 1'b1, 32'h80, 32'h2222_0000, 20'h81);

    wr(20'hFFFFF, 16'h0AAA);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick(); check("wrap_addr", {44'h0, mem_addr}, 64'hFFFFF);
    redirect_valid = 1'b0;
    tick(); chk_out("wrap", 1'b1, 32'hFFFF_FFFF, 32'h0AAA_0000, 20'h0);

    redirect_valid = 1'b1;
    redirect_pc = 32'h90;
    tick(); redirect_valid = 1'b0;
    tick(); chk_out("pre_reset_fetch2", 1'b0, 32'hFFFF_FFFF, 32'h0AAA_0000, 20'h91);
    stall = 1'b1;
    tick();
    #3 rst = 1'b0;
    #1 chk_out("midop_reset", 1'b0, 32'h0, 32'h0, 20'h0);
    check("midop_reset_buf_en", {63'h0, o_buf_enable}, 64'h0);
    stall = 1'b0;

    for (int a = 32'h40; a < 32'h140; a++)
      wr(20'(a), {$urandom_range(65535, 0)} & 16'hFFFE | 16'(($urandom % 10) < 4));
    release_reset();
    check("revec_hi_addr", {44'h0, mem_addr}, 64'h0);
    tick(); check("revec_lo_addr", {44'h0, mem_addr}, 64'h1);
    tick(); check("revec_fetch_addr", {44'h0, mem_addr}, 64'h40);

    captures = 0;
    for (int k = 0; k < 2000; k++) begin
      stall = ($urandom % 4) == 0;
      redirect_valid = ($urandom % 20) == 0;
      if ($urandom % 8 == 0) redirect_pc = 32'hFFFF_FFF0 + ($urandom % 16);
      else redirect_pc = 32'h40 + ($urandom % 256);
      tick();
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    repeat (4) tick();
    check("random_progress", {63'h0, captures >= 200}, 64'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
